deser_queue_top: RTL and testbench

//   Serial-to-parallel front end feeding a word FIFO. Bits arrive one per write_in strobe on data_in, LSB first.

---
 rtl/deser_queue_pkg.sv | 28 ++
 rtl/deser_queue_if.sv | 27 ++
 rtl/word_fifo.sv | 76 +++++++
 rtl/deser_queue_top.sv | 100 ++++++++++
 tb/tb_deser_queue_top.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/deser_queue_pkg.sv
// -----------------------------------------------------------------------------
// deser_queue_pkg
//   Shared constants and types for the serial-to-parallel word queue.
//   WORD_W : width of an assembled word / queue entry
//   DEPTH  : queue depth in words
//   LEN_W  : width of the occupancy count (holds 0..DEPTH)
// -----------------------------------------------------------------------------
package deser_queue_pkg;

    localparam int WORD_W = 8;
    localparam int DEPTH  = 8;
    localparam int LEN_W  = 4;

    localparam int CNT_W  = $clog2(WORD_W);
    localparam int PTR_W  = $clog2(DEPTH);

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [LEN_W-1:0]  len_t;
    typedef logic [PTR_W-1:0]  ptr_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    // Circular pointer advance; the explicit wrap keeps the queue correct
    // even if DEPTH is later changed to a non-power-of-two.
    function automatic ptr_t next_ptr(input ptr_t p);
        return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
    endfunction

endpackage

// File: rtl/deser_queue_if.sv
// -----------------------------------------------------------------------------
// deser_queue_if
//   Bundles the serial producer / byte consumer signals of deser_queue_top.
//   master : drives data_in, write_in, dequeue_in; observes the outputs
//   slave  : the queue itself; drives status_out, len_out, data_out
// -----------------------------------------------------------------------------
interface deser_queue_if;
    import deser_queue_pkg::*;

    logic  data_in;
    logic  write_in;
    logic  dequeue_in;
    logic  status_out;
    len_t  len_out;
    word_t data_out;

    modport master (
        output data_in, write_in, dequeue_in,
        input  status_out, len_out, data_out
    );

    modport slave (
        input  data_in, write_in, dequeue_in,
        output status_out, len_out, data_out
    );

endinterface

// File: rtl/word_fifo.sv
// -----------------------------------------------------------------------------
// word_fifo
//   DEPTH-entry circular word queue with a registered pop output.
//   clock      : rising-edge clock
//   reset      : asynchronous active-low reset
//   push       : enqueue word this cycle
//   pop        : dequeue head onto data_out this cycle (ignored when empty)
//   word       : word to enqueue
//   data_out   : last popped word, held until the next successful pop
//   count      : current occupancy
//   count_next : occupancy after this cycle's push/pop
// -----------------------------------------------------------------------------
module word_fifo
    import deser_queue_pkg::*;
(
    input  logic  clock,
    input  logic  reset,
    input  logic  push,
    input  logic  pop,
    input  word_t word,
    output word_t data_out,
    output len_t  count,
    output len_t  count_next
);

    word_t mem [DEPTH];
    ptr_t  wr_ptr;
    ptr_t  rd_ptr;
    logic  push_ok;
    logic  pop_ok;

    // An empty queue has nothing to pop, even if a word is being written in
    // the same cycle: the new word only becomes visible next cycle.
    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        push_ok    = push && (count != len_t'(DEPTH));
        pop_ok     = pop  && (count != '0);
        count_next = count;
        if (push_ok && !pop_ok) begin
            count_next = count + len_t'(1);
        end else if (pop_ok && !push_ok) begin
            count_next = count - len_t'(1);
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            data_out <= '0;
        end else begin
            count <= count_next;
            if (push_ok) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop_ok) begin
                data_out <= mem[rd_ptr];
                rd_ptr   <= next_ptr(rd_ptr);
            end
        end
    end

    // NOTE: the storage array is deliberately not reset; count gates every
    // read, so stale contents are never observable and the array can map
    // onto plain RAM/flops without a reset network.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= word;
        end
    end

endmodule

// File: rtl/deser_queue_top.sv
// -----------------------------------------------------------------------------
// deser_queue_top
//   Serial-to-parallel front end feeding a word FIFO. One bit is taken from
//   data_in per rising edge of write_in, LSB first; every WORD_W bits form a
//   word that is pushed into the queue. Each rising edge of dequeue_in pops
//   the head word onto data_out.
//   clock          : rising-edge system clock
//   reset          : asynchronous active-low reset
//   bus.data_in    : serial data bit, captured on the write_in rising edge
//   bus.write_in   : bit strobe, one bit per 0->1 transition
//   bus.dequeue_in : pop strobe, one pop per 0->1 transition
//   bus.status_out : 1 = ready to accept bits (not full, no push pending)
//   bus.len_out    : queue occupancy 0..DEPTH
//   bus.data_out   : last popped word
// -----------------------------------------------------------------------------
module deser_queue_top
    import deser_queue_pkg::*;
(
    input  logic          clock,
    input  logic          reset,
    deser_queue_if.slave  bus
);

    // Strobe edge detection: history flops plus a registered event, so a
    // strobe held high for many cycles produces a single one-cycle event the
    // cycle after the edge is seen. The data bit is captured with the edge.
    logic write_hist;
    logic dequeue_hist;
    logic write_evt;
    logic dequeue_evt;
    logic data_bit;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            write_hist   <= 1'b0;
            dequeue_hist <= 1'b0;
            write_evt    <= 1'b0;
            dequeue_evt  <= 1'b0;
            data_bit     <= 1'b0;
        end else begin
            write_hist   <= bus.write_in;
            dequeue_hist <= bus.dequeue_in;
            write_evt    <= bus.write_in & ~write_hist;
            dequeue_evt  <= bus.dequeue_in & ~dequeue_hist;
            if (bus.write_in && !write_hist) begin
                data_bit <= bus.data_in;
            end
        end
    end

    // Deserializer
    word_t shift;
    cnt_t  cnt;
    logic  push_pend;
    logic  status_q;
    logic  accept;
    logic  last_bit;
    len_t  count;
    len_t  count_next;
    word_t fifo_data;

    // Bits arriving while status_q is low are dropped without moving cnt.
    assign accept   = write_evt & status_q;
    assign last_bit = accept && (cnt == cnt_t'(WORD_W - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shift     <= '0;
            cnt       <= '0;
            push_pend <= 1'b0;
            status_q  <= 1'b0;
        end else begin
            if (accept) begin
                shift[cnt] <= data_bit;
                cnt        <= last_bit ? '0 : cnt + cnt_t'(1);
            end
            // The completed word (including the last bit just written into
            // shift) is enqueued on the following cycle.
            push_pend <= last_bit;
            // Low through the push cycle, and whenever the queue will be full.
            status_q  <= !last_bit && (count_next != len_t'(DEPTH));
        end
    end

    word_fifo u_word_fifo (
        .clock      (clock),
        .reset      (reset),
        .push       (push_pend),
        .pop        (dequeue_evt),
        .word       (shift),
        .data_out   (fifo_data),
        .count      (count),
        .count_next (count_next)
    );

    assign bus.status_out = status_q;
    assign bus.len_out    = count;
    assign bus.data_out   = fifo_data;

endmodule

// File: tb/tb_deser_queue_top.sv
// -----------------------------------------------------------------------------
// tb_deser_queue_top
//   Self-checking bench for deser_queue_top. A table of operations (send a
//   byte, send a lone bit, pop) carries the expected occupancy and status;
//   popped data is checked against a scoreboard queue filled as bytes are
//   sent. Hand-written sequences cover empty pops, held strobes and reset
//   in the middle of a word.
// -----------------------------------------------------------------------------
module tb_deser_queue_top;
    import deser_queue_pkg::*;

    typedef enum logic [1:0] {OP_BYTE, OP_BIT, OP_POP} op_e;

    typedef struct {
        op_e        op;
        logic [7:0] value;
        logic [3:0] exp_len;
        logic       exp_status;
    } vec_t;

    logic clock;
    logic reset;

    deser_queue_if bus ();

    deser_queue_top dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: scoreboard of complete words plus partial bit state.
    logic [7:0] sb_q[$];
    logic [7:0] model_shift;
    int         model_cnt;
    logic [7:0] model_data;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic model_reset();
        sb_q.delete();
        model_shift = '0;
        model_cnt   = 0;
        model_data  = '0;
    endtask

    // One strobe: 10 cycles high, 10 cycles low. The model takes the bit
    // only while the queue has room.
    task automatic send_bit(input logic b);
        bus.data_in  = b;
        bus.write_in = 1'b1;
        cycles(10);
        bus.write_in = 1'b0;
        cycles(10);
        if (sb_q.size() < DEPTH) begin
            model_shift[model_cnt] = b;
            model_cnt++;
            if (model_cnt == 8) begin
                sb_q.push_back(model_shift);
                model_cnt = 0;
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) send_bit(v[i]);
    endtask

    task automatic pop_pulse(input int high_cycles);
        bus.dequeue_in = 1'b1;
        cycles(high_cycles);
        bus.dequeue_in = 1'b0;
        cycles(10);
        if (sb_q.size() > 0) model_data = sb_q.pop_front();
    endtask

    task automatic add(input op_e op, input logic [7:0] v, input logic [3:0] l, input logic s);
        vec_t r;
        r.op = op; r.value = v; r.exp_len = l; r.exp_status = s;
        vecs.push_back(r);
    endtask

    initial begin
        reset          = 1'b0;
        bus.data_in    = 1'b0;
        bus.write_in   = 1'b0;
        bus.dequeue_in = 1'b0;
        model_reset();

        // ---- Vector table ----
        // Single 0x99 round trip
        add(OP_BYTE, 8'h99, 4'd1, 1'b1);
        add(OP_POP,  8'h00, 4'd0, 1'b1);
        // Two words in order
        add(OP_BYTE, 8'h99, 4'd1, 1'b1);
        add(OP_BYTE, 8'h0F, 4'd2, 1'b1);
        add(OP_POP,  8'h00, 4'd1, 1'b1);
        add(OP_POP,  8'h00, 4'd0, 1'b1);
        // Fill to DEPTH (pointers wrap), extra bits ignored when full
        for (int i = 0; i < 8; i++)
            add(OP_BYTE, 8'(i), 4'(i + 1), (i != 7));
        for (int i = 0; i < 3; i++)
            add(OP_BIT, 8'h01, 4'd8, 1'b0);
        // First pop reopens intake, then drain
        for (int i = 0; i < 8; i++)
            add(OP_POP, 8'h00, 4'(7 - i), 1'b1);

        // ---- Reset held, then released ----
        cycles(5);
        check("reset_status", 32'(bus.status_out), 32'd0);
        check("reset_len",    32'(bus.len_out),    32'd0);
        check("reset_data",   32'(bus.data_out),   32'h00);
        reset = 1'b1;
        cycles(2);
        check("release_status", 32'(bus.status_out), 32'd1);
        check("release_len",    32'(bus.len_out),    32'd0);
        check("release_data",   32'(bus.data_out),   32'h00);

        // ---- Table-driven run ----
        foreach (vecs[k]) begin
            case (vecs[k].op)
                OP_BYTE: send_byte(vecs[k].value);
                OP_BIT:  send_bit(vecs[k].value[0]);
                default: begin
                    pop_pulse(10);
                    check($sformatf("vec%0d_data", k), 32'(bus.data_out), 32'(model_data));
                end
            endcase
            check($sformatf("vec%0d_len", k),    32'(bus.len_out),    32'(vecs[k].exp_len));
            check($sformatf("vec%0d_status", k), 32'(bus.status_out), 32'(vecs[k].exp_status));
        end

        // ---- Pop while empty: nothing changes ----
        pop_pulse(10);
        check("empty_pop_data", 32'(bus.data_out), 32'h07);
        check("empty_pop_len",  32'(bus.len_out),  32'd0);

        // ---- Long dequeue strobe pops exactly once ----
        send_byte(8'h3C);
        send_byte(8'hC3);
        check("two_queued_len", 32'(bus.len_out), 32'd2);
        pop_pulse(20);
        check("held_pop_data", 32'(bus.data_out), 32'(model_data));
        check("held_pop_len",  32'(bus.len_out),  32'd1);
        pop_pulse(10);
        check("held_pop2_data", 32'(bus.data_out), 32'hC3);
        check("held_pop2_len",  32'(bus.len_out),  32'd0);

        // ---- Reset mid-word with words queued ----
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        check("pre_reset_len", 32'(bus.len_out), 32'd3);
        reset = 1'b0;
        #1;
        check("mid_reset_len",    32'(bus.len_out),    32'd0);
        check("mid_reset_data",   32'(bus.data_out),   32'h00);
        check("mid_reset_status", 32'(bus.status_out), 32'd0);
        model_reset();
        cycles(3);
        reset = 1'b1;
        cycles(2);
        send_byte(8'hA5);
        check("post_reset_len", 32'(bus.len_out), 32'd1);
        pop_pulse(10);
        check("post_reset_data", 32'(bus.data_out), 32'hA5);
        check("post_reset_len0", 32'(bus.len_out),  32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
